ld_st_iq_age_scheduler: RTL and testbench
=========================================

// Module: ld_st_iq_age_scheduler
// PURPOSE
//  Allocation and age-ordered issue controller for the load/store issue queue.
//  - Picks a free entry for each dispatched memory op and drives the queue's wen/waddr.
//  - Tracks relative age of all resident entries with an age matrix.
//  - Selects one ready entry per cycle for the memory unit; drives raddr/complete.
//  - Placement: between dispatch/rename and the queue (queue output side feeds the memory unit).
// PARAMETERS
//  QUEUE_DEPTH  4  queue entries; power of two, >=2; must match the queue instance
// PORTS
//  clk                  in   1          clock
//  rst                  in   1          synchronous active-high reset
//  dispatch_valid       in   1          rename presents a ld/st packet
//  dispatch_is_store    in   1          1=store, 0=load; sampled with dispatch
//  dispatch_ready       out  1          a free entry exists this cycle
//  rs_queue_valid_bits  in   DEPTH      queue registered valid bits
//  rs_ready_bits        in   DEPTH      queue per-entry ready (incl. same-cycle CDB wakeup, squash)
//  rs_station_wen       out  1          write dispatch packet into queue
//  rs_station_waddr     out  log2(D)    entry written
//  rs_station_raddr     out  log2(D)    entry selected for issue (drives queue rs_pkt_out)
//  rs_station_complete  out  1          selected entry leaves queue this cycle
//  issue_valid          out  1          rs_pkt_out is a legal issue candidate
//  issue_ready          in   1          memory unit accepts the candidate
//  occupancy            out  log2(D)+1  popcount of rs_queue_valid_bits
// BEHAVIOUR
//  - State: age matrix older[i][j] (1 = entry j older than entry i, DxD bits).
//    Also is_st[D], captured per entry at allocation.
//  - Allocation (combinational):
//    - free = ~rs_queue_valid_bits; waddr = lowest free index.
//    - dispatch_ready = |free; rs_station_wen = dispatch_valid & dispatch_ready.
//    - An entry completing this cycle is NOT reusable until the next cycle (valid still 1).
//  - On wen to entry k (posedge):
//    - older[k][j] <= rs_queue_valid_bits[j] for all j != k; older[k][k] <= 0.
//    - older[i][k] <= 0 for all i.
//    - is_st[k] <= dispatch_is_store.
//  - Age comparisons always mask with rs_queue_valid_bits; rows/columns of invalid entries
//    are don't-care, so branch-squashed entries need no extra cleanup.
//  - Eligibility (default): entry i is eligible iff valid, ready, and it is the oldest valid
//    entry: no j with valid[j] & older[i][j]. This gives strict in-order issue.
//  - issue_valid = |eligible; raddr = the eligible index, or 0 when none.
//  - rs_station_complete = issue_valid & issue_ready (same cycle, zero latency).
//  - Dispatch and issue in the same cycle always target different entries; both take effect.
//  - Full: dispatch_ready = 0 and wen = 0; dispatch must hold until space frees (next cycle at
//    the earliest).
//  - Empty: issue_valid = 0, complete = 0, raddr = 0, occupancy = 0.
//  - Reset (incl. mid-operation): older <= 0, is_st <= 0. Outputs follow from queue valids,
//    which the queue also clears on rst; the cycle after reset all outputs are 0 and
//    dispatch_ready = 1.
// CONFIGURATION
//  LDST_OOO_LOAD_EN defined:
//    - A load is eligible if valid & ready & no valid older entry is a store.
//      Loads may pass older unready loads.
//    - A store is eligible only when it is the oldest valid entry.
//    - If several entries are eligible, the oldest one is chosen: the eligible i with no
//      eligible j older than it.
//  Undefined: strict in-order issue as above; is_st is still stored but unused.
// TESTING
//  1. Reset; dispatch 4 ops -> waddr 0,1,2,3; dispatch_ready=0 after the 4th; occupancy=4.
//  2. Entries 0..3 resident, only entry 2 ready:
//     - default: issue_valid=0.
//     - LDST_OOO_LOAD_EN with all loads: raddr=2, complete=1 with issue_ready=1.
//  3. Store at entry 0 unready, load at entry 1 ready -> issue_valid=0 in both configs;
//     make store ready -> raddr=0 issues first, load 1 next cycle.
//  4. Full queue, issue_ready=1, dispatch_valid=1 -> cycle 0: complete=1, wen=0;
//     cycle 1: wen=1, waddr = freed entry, new entry youngest.
//  5. Squash entries 1,3 (valids drop) then dispatch -> waddr=1; age order of 0,2 preserved;
//     the new op issues last.
//  6. Assert rst while 3 entries resident and issue_ready=1 -> next cycle complete=0,
//     issue_valid=0, dispatch_ready=1, older=0.

Source files
------------

// File: rtl/ld_st_iq_age_scheduler.sv
// ld_st_iq_age_scheduler: allocation and age-ordered issue control for the
// load/store issue queue. An age matrix orders resident entries; free entries
// are allocated lowest-index first and one eligible entry is selected per cycle.
// Optional macro LDST_OOO_LOAD_EN lets loads bypass older non-store entries;
// without it, issue is strictly in order.
module ld_st_iq_age_scheduler #(
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dispatch_valid,
    input  logic                             dispatch_is_store,
    output logic                             dispatch_ready,
    input  logic [QUEUE_DEPTH-1:0]           rs_queue_valid_bits,
    input  logic [QUEUE_DEPTH-1:0]           rs_ready_bits,
    output logic                             rs_station_wen,
    output logic [$clog2(QUEUE_DEPTH)-1:0]   rs_station_waddr,
    output logic [$clog2(QUEUE_DEPTH)-1:0]   rs_station_raddr,
    output logic                             rs_station_complete,
    output logic                             issue_valid,
    input  logic                             issue_ready,
    output logic [$clog2(QUEUE_DEPTH):0]     occupancy
);

    localparam int unsigned AW = $clog2(QUEUE_DEPTH);

    // older[i][j] = 1 means entry j is older than entry i
    logic [QUEUE_DEPTH-1:0] older [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] is_st;

    logic [QUEUE_DEPTH-1:0] free;
    logic [QUEUE_DEPTH-1:0] has_older_valid;
    logic [QUEUE_DEPTH-1:0] has_older_store;
    logic [QUEUE_DEPTH-1:0] eligible;
    logic                   waddr_found;

    // Age matrix and store flags: a new entry is younger than every valid entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                older[i] <= '0;
            end
            is_st <= '0;
        end else if (rs_station_wen) begin
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                if (AW'(i) != rs_station_waddr) begin
                    older[i][rs_station_waddr] <= 1'b0;
                end
            end
            older[rs_station_waddr] <= rs_queue_valid_bits
                                       & ~(QUEUE_DEPTH'(1) << rs_station_waddr);
            is_st[rs_station_waddr] <= dispatch_is_store;
        end
    end

    // Allocation: lowest free index, occupancy popcount
    always_comb begin
        free             = ~rs_queue_valid_bits;
        dispatch_ready   = |free;
        rs_station_wen   = dispatch_valid & dispatch_ready;
        rs_station_waddr = '0;
        waddr_found      = 1'b0;
        occupancy        = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (free[i] && !waddr_found) begin
                rs_station_waddr = AW'(i);
                waddr_found      = 1'b1;
            end
            occupancy = occupancy + (AW+1)'(rs_queue_valid_bits[i]);
        end
    end

    // Eligibility: age comparisons are always masked by current valid bits
    always_comb begin
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            has_older_valid[i] = |(older[i] & rs_queue_valid_bits);
            has_older_store[i] = |(older[i] & rs_queue_valid_bits & is_st);
`ifdef LDST_OOO_LOAD_EN
            eligible[i] = rs_queue_valid_bits[i] & rs_ready_bits[i] &
                          (is_st[i] ? ~has_older_valid[i] : ~has_older_store[i]);
`else
            // older-store term is a subset of older-valid, so this is plain in-order
            eligible[i] = rs_queue_valid_bits[i] & rs_ready_bits[i] &
                          ~(has_older_valid[i] | has_older_store[i]);
`endif
        end
    end

    // Selection: oldest eligible entry (no eligible entry older than it)
    always_comb begin
        issue_valid         = |eligible;
        rs_station_raddr    = '0;
        for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
            if (eligible[i] && !(|(older[i] & eligible))) begin
                rs_station_raddr = AW'(i);
            end
        end
        rs_station_complete = issue_valid & issue_ready;
    end

endmodule

// File: tb/tb_ld_st_iq_age_scheduler.sv
// Directed bench for ld_st_iq_age_scheduler; a small queue model supplies
// the registered valid bits the scheduler expects from the issue queue.
module tb_ld_st_iq_age_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       dispatch_valid;
    logic       dispatch_is_store;
    logic       dispatch_ready;
    logic [3:0] q_valid;
    logic [3:0] ready_bits;
    logic [3:0] squash;
    logic       wen;
    logic [1:0] waddr;
    logic [1:0] raddr;
    logic       complete;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] occupancy;

    int tests_run    = 0;
    int tests_failed = 0;

    ld_st_iq_age_scheduler #(.QUEUE_DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .dispatch_valid      (dispatch_valid),
        .dispatch_is_store   (dispatch_is_store),
        .dispatch_ready      (dispatch_ready),
        .rs_queue_valid_bits (q_valid),
        .rs_ready_bits       (ready_bits),
        .rs_station_wen      (wen),
        .rs_station_waddr    (waddr),
        .rs_station_raddr    (raddr),
        .rs_station_complete (complete),
        .issue_valid         (issue_valid),
        .issue_ready         (issue_ready),
        .occupancy           (occupancy)
    );

    always #5 clk = ~clk;

    // Queue valid bits: set on write, cleared on complete or squash
    always @(posedge clk) begin
        if (rst) q_valid <= '0;
        else     q_valid <= ((q_valid & ~(complete ? (4'b0001 << raddr) : 4'b0000))
                             | (wen ? (4'b0001 << waddr) : 4'b0000)) & ~squash;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst = 1'b1; dispatch_valid = 1'b0; issue_ready = 1'b0;
        ready_bits = '0; squash = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic do_dispatch(input logic st, input logic [1:0] exp_addr);
        dispatch_valid = 1'b1; dispatch_is_store = st;
        #1;
        check("disp_wen", wen, 1);
        check("disp_waddr", waddr, exp_addr);
        step();
        dispatch_valid = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [1:0] exp_addr);
        #1;
        check({tag, "_valid"}, issue_valid, 1);
        check({tag, "_raddr"}, raddr, exp_addr);
        check({tag, "_complete"}, complete, issue_ready);
        step();
    endtask

    initial begin
        rst = 1'b1; dispatch_valid = 1'b0; dispatch_is_store = 1'b0;
        ready_bits = '0; issue_ready = 1'b0; squash = '0;
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_dready", dispatch_ready, 1);
        check("rst_ivalid", issue_valid, 0);
        check("rst_complete", complete, 0);
        check("rst_raddr", raddr, 0);
        check("rst_occ", occupancy, 0);
        check("rst_wen", wen, 0);
        step();

        // 1: fill in order 0..3, then full
        for (int k = 0; k < 4; k++) do_dispatch(1'b0, 2'(k));
        dispatch_valid = 1'b1;
        #1;
        check("full_dready", dispatch_ready, 0);
        check("full_wen", wen, 0);
        check("full_occ", occupancy, 4);
        step();
        dispatch_valid = 1'b0;

        // 2: only entry 2 ready
        ready_bits = 4'b0100; issue_ready = 1'b1;
        #1;
`ifdef LDST_OOO_LOAD_EN
        check("ooo_ivalid", issue_valid, 1);
        check("ooo_raddr", raddr, 2);
        check("ooo_complete", complete, 1);
`else
        check("ino_ivalid", issue_valid, 0);
        check("ino_complete", complete, 0);
`endif
        issue_ready = 1'b0;
        step();

        // 3: store at 0 unready blocks ready load at 1
        reset_dut();
        do_dispatch(1'b1, 2'd0);
        do_dispatch(1'b0, 2'd1);
        ready_bits = 4'b0010; issue_ready = 1'b1;
        #1;
        check("st_block_ivalid", issue_valid, 0);
        check("st_block_complete", complete, 0);
        step();
        ready_bits = 4'b0011;
        expect_issue("st_first", 2'd0);
        expect_issue("ld_next", 2'd1);
        #1;
        check("empty_ivalid", issue_valid, 0);
        check("empty_raddr", raddr, 0);
        check("empty_occ", occupancy, 0);
        step();

        // 4: full queue, issue and dispatch together
        reset_dut();
        for (int k = 0; k < 4; k++) do_dispatch(1'b0, 2'(k));
        ready_bits = 4'b1111; issue_ready = 1'b1; dispatch_valid = 1'b1;
        #1;
        check("c0_complete", complete, 1);
        check("c0_raddr", raddr, 0);
        check("c0_wen", wen, 0);
        step();
        #1;
        check("c1_wen", wen, 1);
        check("c1_waddr", waddr, 0);
        check("c1_raddr", raddr, 1);
        check("c1_complete", complete, 1);
        step();
        dispatch_valid = 1'b0;
        expect_issue("c2", 2'd2);
        expect_issue("c3", 2'd3);
        expect_issue("c4_youngest", 2'd0);
        #1;
        check("c5_ivalid", issue_valid, 0);
        step();

        // 5: squash 1 and 3, reallocate 1, order 0,2,new
        reset_dut();
        for (int k = 0; k < 4; k++) do_dispatch(1'b0, 2'(k));
        squash = 4'b1010;
        step();
        squash = 4'b0000;
        #1;
        check("sq_occ", occupancy, 2);
        step();
        do_dispatch(1'b0, 2'd1);
        ready_bits = 4'b1111; issue_ready = 1'b1;
        expect_issue("sq_0", 2'd0);
        expect_issue("sq_2", 2'd2);
        expect_issue("sq_new", 2'd1);
        #1;
        check("sq_empty", issue_valid, 0);
        step();

        // 6: reset mid-operation
        reset_dut();
        for (int k = 0; k < 3; k++) do_dispatch(1'b0, 2'(k));
        ready_bits = 4'b0111; issue_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("mr_complete", complete, 0);
        check("mr_ivalid", issue_valid, 0);
        check("mr_dready", dispatch_ready, 1);
        check("mr_occ", occupancy, 0);
        for (int i = 0; i < 4; i++) check("mr_older", 32'(dut.older[i]), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
